kmap_sweep_capture: RTL and testbench
=====================================

KMAP_SWEEP_CAPTURE -- requirements
Module: kmap_sweep_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, giving the cycles each vector is held before f_in is sampled (legal 1..15).
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: sweep request, sampled only in IDLE.
REQ-005 SHALL have port abcde, output, 5: vector driven to the downstream 5-input function block, with A = bit 4 and E = bit 0.
REQ-006 SHALL have port f_in, input, 1: function output returned from that block.
REQ-007 SHALL have port busy, output, 1: high in SWEEP and PRESENT.
REQ-008 SHALL have port table_out, output, 32: captured truth table, where bit i is f_in for abcde == i.
REQ-009 SHALL have port ones_count, output, 6: number of 1 bits in table_out (0..32).
REQ-010 SHALL have port table_valid, output, 1: result offered to the consumer.
REQ-011 SHALL have port table_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on handshake completion.

Function
REQ-013 SHALL implement FSM states IDLE, SWEEP and PRESENT.
REQ-014 In IDLE with start=1, the FSM SHALL go to SWEEP on the next edge, with abcde=0, settle counter=0, table_out=0 and ones_count=0.
REQ-015 In SWEEP, abcde SHALL be held for exactly SETTLE_CYCLES cycles; on the last of those edges f_in SHALL be written to table_out[abcde], ones_count SHALL be incremented when f_in=1, and abcde SHALL be incremented.
REQ-016 The sample for abcde=31 SHALL move the FSM to PRESENT and set table_valid=1 on the same edge; abcde SHALL NOT wrap and SHALL hold 31 until IDLE is re-entered.
REQ-017 Sweep latency SHALL be 32*SETTLE_CYCLES cycles from the start-accept edge to table_valid=1 (32 cycles at the default).
REQ-018 In PRESENT, table_valid, table_out and ones_count SHALL hold stable until a cycle with table_valid=1 and table_ready=1.
REQ-019 On that handshake edge, the FSM SHALL go to IDLE, table_valid SHALL clear, done SHALL pulse high for exactly one cycle, and table_out/ones_count SHALL keep their values.
REQ-020 start SHALL be ignored in SWEEP and PRESENT; no restart and no queuing.
REQ-021 start=1 in the same cycle that done=1 (FSM now in IDLE) SHALL begin a new sweep on the following edge.
REQ-022 table_ready SHALL be ignored outside PRESENT.
REQ-023 abcde SHALL be 0 in IDLE after reset.

Reset
REQ-024 rst=1 SHALL immediately, without a clock, force IDLE, abcde=0, table_out=0, ones_count=0, table_valid=0, done=0, busy=0 and settle counter=0.
REQ-025 Reset asserted mid-SWEEP or mid-PRESENT SHALL discard the partial or offered result; after rst deasserts, no output SHALL change until a new start.

Configuration
REQ-026 Macro KMAP_SWEEP_GOLDEN_CHECK_EN, when defined, SHALL add output mismatch (1 bit), set on entry to PRESENT to (table_out != 32'hC10CEEA1) and held until the next sweep start or reset.
REQ-027 Without KMAP_SWEEP_GOLDEN_CHECK_EN, port mismatch and all compare logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Reset, start pulse, f_in driven by the golden 5-input function, SETTLE_CYCLES=1 -> table_valid rises 32 cycles after start accept; table_out=32'hC10CEEA1; ones_count=14; mismatch=0 when the macro is enabled.
REQ-029 f_in tied to 1, table_ready held low for 10 cycles after table_valid -> table_valid, table_out=32'hFFFFFFFF and ones_count=32 stay stable; done pulses once, one cycle after table_ready rises.
REQ-030 SETTLE_CYCLES=3, f_in=abcde[0] -> abcde changes every 3 cycles; table_out=32'hAAAAAAAA; ones_count=16; latency 96 cycles; mismatch=1 when enabled.
REQ-031 rst asserted asynchronously while abcde=17 in SWEEP -> all outputs are 0 within the same cycle; extra start pulses applied during the prior busy period have no effect.
REQ-032 start held high continuously with table_ready=1 -> back-to-back sweeps; done pulses every 34 cycles at SETTLE_CYCLES=1 (32 sweep + 1 PRESENT + 1 IDLE).

Source files
------------

// File: rtl/kmap_sweep_capture.sv
// ============================================================================
// kmap_sweep_capture
//
// Purpose:
//   Walks a 5-bit input vector (abcde) through all 32 combinations, holding
//   each value for SETTLE_CYCLES clocks so the downstream combinational block
//   can settle. On the last cycle of each hold it samples f_in into the truth
//   table and keeps a running count of ones. The finished table is then
//   offered with a valid/ready handshake. A one-cycle done pulse marks the
//   handshake.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before f_in is sampled (1..15)
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   start        sweep request, only looked at while idle
//   abcde[4:0]   vector to the function block (A = bit 4, E = bit 0)
//   f_in         function output coming back from that block
//   busy         high while sweeping or presenting a result
//   table_out    captured truth table, bit i = f_in observed for abcde == i
//   ones_count   number of ones in table_out (0..32)
//   table_valid  result is being offered
//   table_ready  consumer accepts the offered result
//   done         one-cycle pulse after the result is accepted
//   mismatch     (only with KMAP_SWEEP_GOLDEN_CHECK_EN) captured table differs
//                from the golden 32'hC10CEEA1
//
// Build option:
//   KMAP_SWEEP_GOLDEN_CHECK_EN  adds the mismatch output and its compare logic
// ============================================================================
module kmap_sweep_capture #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  abcde,
    input  logic        f_in,
    output logic        busy,
    output logic [31:0] table_out,
    output logic [5:0]  ones_count,
    output logic        table_valid,
    input  logic        table_ready,
    output logic        done
`ifdef KMAP_SWEEP_GOLDEN_CHECK_EN
    ,
    output logic        mismatch
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SWEEP   = 2'd1,
        PRESENT = 2'd2
    } state_t;

    // Value of the settle counter on the cycle where f_in is sampled.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  abcde_q, abcde_d;
    logic [3:0]  settle_q, settle_d;
    logic [31:0] table_q, table_d;
    logic [5:0]  ones_q, ones_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    // State register. Reset drops everything back to a cleared idle state
    // without waiting for a clock, discarding any partial or offered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            abcde_q  <= 5'd0;
            settle_q <= 4'd0;
            table_q  <= 32'd0;
            ones_q   <= 6'd0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            abcde_q  <= abcde_d;
            settle_q <= settle_d;
            table_q  <= table_d;
            ones_q   <= ones_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic. Everything holds by default; done is a pulse so it
    // defaults low. The last vector (31) is sampled on the same edge that
    // moves to PRESENT, so abcde never wraps and stays at 31 while the result
    // is offered; it returns to 0 when the result is accepted.
    always_comb begin
        state_d  = state_q;
        abcde_d  = abcde_q;
        settle_d = settle_q;
        table_d  = table_q;
        ones_d   = ones_q;
        valid_d  = valid_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SWEEP;
                    abcde_d  = 5'd0;
                    settle_d = 4'd0;
                    table_d  = 32'd0;
                    ones_d   = 6'd0;
                end
            end

            SWEEP: begin
                if (settle_q == SETTLE_LAST) begin
                    settle_d         = 4'd0;
                    table_d[abcde_q] = f_in;
                    ones_d           = ones_q + {5'd0, f_in};
                    if (abcde_q == 5'd31) begin
                        state_d = PRESENT;
                        valid_d = 1'b1;
                    end else begin
                        abcde_d = abcde_q + 5'd1;
                    end
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end

            PRESENT: begin
                if (table_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    abcde_d = 5'd0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign abcde       = abcde_q;
    assign busy        = (state_q == SWEEP) || (state_q == PRESENT);
    assign table_out   = table_q;
    assign ones_count  = ones_q;
    assign table_valid = valid_q;
    assign done        = done_q;

`ifdef KMAP_SWEEP_GOLDEN_CHECK_EN
    localparam logic [31:0] GOLDEN_TABLE = 32'hC10CEEA1;

    logic mismatch_q, mismatch_d;

    // The compare uses the table value being written on the PRESENT entry
    // edge, so the flag is valid in the same cycle as table_valid.
    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == IDLE && start) begin
            mismatch_d = 1'b0;
        end else if (state_q == SWEEP && state_d == PRESENT) begin
            mismatch_d = (table_d != GOLDEN_TABLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_kmap_sweep_capture.sv
// ============================================================================
// tb_kmap_sweep_capture
//
// Two instances are exercised: dut0 with SETTLE_CYCLES=1 and dut1 with
// SETTLE_CYCLES=3. Each instance's f_in comes from a 32-bit truth table held
// by the bench, indexed by that instance's abcde output. The expected result
// of a sweep is simply that truth table, its population count and a latency
// of 32*SETTLE_CYCLES cycles.
// ============================================================================
module tb_kmap_sweep_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  start = 2'b00;
    logic [1:0]  ready = 2'b00;
    logic [31:0] fn0 = 32'd0;
    logic [31:0] fn1 = 32'd0;

    logic        f_in0, f_in1;
    logic [4:0]  abcde0, abcde1;
    logic        busy0, busy1, valid0, valid1, done0, done1;
    logic [31:0] tbl0, tbl1;
    logic [5:0]  ones0, ones1;
`ifdef KMAP_SWEEP_GOLDEN_CHECK_EN
    logic        mm0, mm1;
`endif

    int passCount  = 0;
    int checkCount = 0;

    localparam logic [31:0] GOLDEN = 32'hC10CEEA1;

    always #5 clk = ~clk;

    // The "function block" each DUT is sweeping.
    assign f_in0 = fn0[abcde0];
    assign f_in1 = fn1[abcde1];

    kmap_sweep_capture #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .abcde(abcde0), .f_in(f_in0),
        .busy(busy0), .table_out(tbl0), .ones_count(ones0),
        .table_valid(valid0), .table_ready(ready[0]), .done(done0)
`ifdef KMAP_SWEEP_GOLDEN_CHECK_EN
        , .mismatch(mm0)
`endif
    );

    kmap_sweep_capture #(.SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .abcde(abcde1), .f_in(f_in1),
        .busy(busy1), .table_out(tbl1), .ones_count(ones1),
        .table_valid(valid1), .table_ready(ready[1]), .done(done1)
`ifdef KMAP_SWEEP_GOLDEN_CHECK_EN
        , .mismatch(mm1)
`endif
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Accessors so one sweep task can drive either instance.
    function automatic logic [31:0] getAbcde(input int d);
        return (d == 0) ? {27'd0, abcde0} : {27'd0, abcde1};
    endfunction
    function automatic logic [31:0] getTbl(input int d);
        return (d == 0) ? tbl0 : tbl1;
    endfunction
    function automatic logic [31:0] getOnes(input int d);
        return (d == 0) ? {26'd0, ones0} : {26'd0, ones1};
    endfunction
    function automatic logic [31:0] getBusy(input int d);
        return (d == 0) ? {31'd0, busy0} : {31'd0, busy1};
    endfunction
    function automatic logic [31:0] getValid(input int d);
        return (d == 0) ? {31'd0, valid0} : {31'd0, valid1};
    endfunction
    function automatic logic [31:0] getDone(input int d);
        return (d == 0) ? {31'd0, done0} : {31'd0, done1};
    endfunction
`ifdef KMAP_SWEEP_GOLDEN_CHECK_EN
    function automatic logic [31:0] getMm(input int d);
        return (d == 0) ? {31'd0, mm0} : {31'd0, mm1};
    endfunction
`endif

    // Checks that every output of both instances is in the cleared state.
    task automatic checkAllClear(input string tag);
        for (int d = 0; d < 2; d++) begin
            checkOutput({tag, "_abcde"}, getAbcde(d), 32'd0);
            checkOutput({tag, "_table"}, getTbl(d), 32'd0);
            checkOutput({tag, "_ones"},  getOnes(d), 32'd0);
            checkOutput({tag, "_busy"},  getBusy(d), 32'd0);
            checkOutput({tag, "_valid"}, getValid(d), 32'd0);
            checkOutput({tag, "_done"},  getDone(d), 32'd0);
`ifdef KMAP_SWEEP_GOLDEN_CHECK_EN
            checkOutput({tag, "_mismatch"}, getMm(d), 32'd0);
`endif
        end
    endtask

    // One complete sweep on instance d with truth table fn, holding ready low
    // for readyDelay cycles after the result appears. Random start and ready
    // noise is applied while busy; it must have no effect.
    task automatic applyStimulus(input int d, input logic [31:0] fn,
                                 input int readyDelay);
        int  s;
        int  lat;
        bit  seen;
        logic [31:0] expOnes;
        s       = (d == 0) ? 1 : 3;
        expOnes = 32'($countones(fn));
        if (d == 0) fn0 = fn; else fn1 = fn;

        @(posedge clk); #1 start[d] = 1'b1;
        @(posedge clk); #1 start[d] = 1'b0;
        checkOutput("accept_busy",  getBusy(d),  32'd1);
        checkOutput("accept_abcde", getAbcde(d), 32'd0);
        checkOutput("accept_table", getTbl(d),   32'd0);
        checkOutput("accept_ones",  getOnes(d),  32'd0);
        checkOutput("accept_valid", getValid(d), 32'd0);
`ifdef KMAP_SWEEP_GOLDEN_CHECK_EN
        checkOutput("accept_mismatch", getMm(d), 32'd0);
`endif

        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40 * s) begin
            start[d] = 1'($urandom_range(0, 1));
            ready[d] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            lat++;
            if (getValid(d) == 32'd1) seen = 1'b1;
            else checkOutput("sweep_abcde", getAbcde(d), 32'(lat / s));
        end
        start[d] = 1'b0;
        ready[d] = 1'b0;

        checkOutput("valid_seen", {31'd0, seen}, 32'd1);
        checkOutput("latency",    32'(lat), 32'(32 * s));
        checkOutput("table",      getTbl(d),   fn);
        checkOutput("ones",       getOnes(d),  expOnes);
        checkOutput("present_abcde", getAbcde(d), 32'd31);
        checkOutput("present_busy",  getBusy(d),  32'd1);
        checkOutput("present_done",  getDone(d),  32'd0);
`ifdef KMAP_SWEEP_GOLDEN_CHECK_EN
        checkOutput("mismatch", getMm(d), {31'd0, (fn != GOLDEN)});
`endif

        repeat (readyDelay) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", getValid(d), 32'd1);
            checkOutput("hold_table", getTbl(d),   fn);
            checkOutput("hold_ones",  getOnes(d),  expOnes);
            checkOutput("hold_done",  getDone(d),  32'd0);
        end

        ready[d] = 1'b1;
        @(posedge clk); #1 ready[d] = 1'b0;
        checkOutput("hs_valid", getValid(d), 32'd0);
        checkOutput("hs_done",  getDone(d),  32'd1);
        checkOutput("hs_busy",  getBusy(d),  32'd0);
        checkOutput("hs_table", getTbl(d),   fn);
        checkOutput("hs_ones",  getOnes(d),  expOnes);
        checkOutput("hs_abcde", getAbcde(d), 32'd0);

        @(posedge clk); #1;
        checkOutput("post_done",  getDone(d),  32'd0);
        checkOutput("post_busy",  getBusy(d),  32'd0);
        checkOutput("post_table", getTbl(d),   fn);
    endtask

    // start and ready held high: sweeps run back to back, done every 34 cycles.
    task automatic runBackToBack();
        int pulses[$];
        fn0      = $urandom;
        start[0] = 1'b1;
        ready[0] = 1'b1;
        for (int t = 0; t < 200 && pulses.size() < 4; t++) begin
            @(posedge clk); #1;
            if (done0) begin
                pulses.push_back(t);
                checkOutput("b2b_table", tbl0, fn0);
            end
        end
        checkOutput("b2b_pulses", 32'(pulses.size()), 32'd4);
        for (int i = 1; i < pulses.size(); i++)
            checkOutput("b2b_period", 32'(pulses[i] - pulses[i-1]), 32'd34);
        start[0] = 1'b0;
        ready[0] = 1'b0;
    endtask

    // Asynchronous reset in the middle of a SETTLE_CYCLES=3 sweep.
    task automatic runMidSweepReset();
        int n;
        fn1 = $urandom;
        @(posedge clk); #1 start[1] = 1'b1;
        @(posedge clk); #1 start[1] = 1'b0;
        n = 0;
        while (abcde1 != 5'd17 && n < 200) begin
            start[1] = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        start[1] = 1'b0;
        checkOutput("reached_17", {27'd0, abcde1}, 32'd17);
        #2 rst = 1'b1;
        #1 checkAllClear("async_rst");
        @(negedge clk) rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            checkAllClear("after_rst");
        end
    endtask

    initial begin
        // Reset is asserted from time zero; outputs must be clear before any
        // clock edge has occurred.
        #2 checkAllClear("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkAllClear("idle");

        applyStimulus(0, GOLDEN,        2);
        applyStimulus(0, 32'hFFFFFFFF, 10);
        applyStimulus(1, 32'hAAAAAAAA,  1);
        for (int i = 0; i < 4; i++)
            applyStimulus(i % 2, $urandom, $urandom_range(0, 4));

        runBackToBack();
        runMidSweepReset();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
